// File: rtl/fixed_point_div_collector_pkg.sv
// Shared types for the divider result collector: the buffered result entry
// and the overflow-counter width.
package fixed_point_div_collector_pkg;

  localparam int OVF_CNT_W  = 16;
  // Widest quotient an entry can carry; narrower quotients sit in the low bits.
  localparam int RES_DATA_W = 32;

  typedef struct packed {
    logic [RES_DATA_W-1:0] data;
    logic                  upflow;
    logic                  downflow;
  } result_entry_t;

endpackage

// File: rtl/fixed_point_result_fifo.sv
// Synchronous result buffer with DEPTH entries and an occupancy output.
// Only the control state resets; the storage array does not.
module fixed_point_result_fifo
  import fixed_point_div_collector_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  result_entry_t wr_entry,
  input  logic          rd_en,
  output result_entry_t rd_entry,
  output logic [AW:0]   occupancy
);

  result_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_rd = rd_en && (occupancy != '0);
  // A write into a full buffer is only legal when a pop frees a slot at the same edge.
  assign do_wr = wr_en && ((occupancy != (AW+1)'(DEPTH)) || do_rd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/fixed_point_div_collector.sv
// Collects quotients from a fixed-latency divider into an ordered buffer,
// issuing launch credits so that no result can ever be dropped.
module fixed_point_div_collector
  import fixed_point_div_collector_pkg::*;
#(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WOI+WOF-1:0]   div_out,
  input  logic                 div_upflow,
  input  logic                 div_downflow,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WOI+WOF-1:0]   m_data,
  output logic                 m_upflow,
  output logic                 m_downflow,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 1);

  logic [LAT-1:0] tags;
  logic [CW-1:0]  in_flight;
  logic [CW-1:0]  credit_used;
  logic [AW:0]    occupancy;
  logic           launch;
  logic           pop;
  result_entry_t  wr_entry;
  result_entry_t  rd_entry;
  logic           data_unused;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LAT; i++) in_flight = in_flight + CW'(tags[i]);
  end

  // Every outstanding tag already owns a buffer slot.
  assign credit_used = CW'(occupancy) + in_flight;
  assign in_ready    = credit_used < CW'(DEPTH);
  assign launch      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tags <= '0;
    end else begin
      tags[0] <= launch;
      for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_comb begin
    wr_entry                    = '0;
    wr_entry.data[WOI+WOF-1:0]  = div_out;
    wr_entry.upflow             = div_upflow;
    wr_entry.downflow           = div_downflow;
  end

  fixed_point_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (tags[LAT-1]),
    .wr_entry  (wr_entry),
    .rd_en     (pop),
    .rd_entry  (rd_entry),
    .occupancy (occupancy)
  );

  assign m_valid     = (occupancy != '0);
  assign pop         = m_valid && m_ready;
  assign m_data      = rd_entry.data[WOI+WOF-1:0];
  assign m_upflow    = rd_entry.upflow;
  assign m_downflow  = rd_entry.downflow;
  assign data_unused = ^rd_entry.data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (pop && (rd_entry.upflow || rd_entry.downflow) && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fixed_point_div_collector.sv
// Directed bench for fixed_point_div_collector; the divider is modelled as a
// LAT-deep pipeline of a reference fixed-point division.
module tb_fixed_point_div_collector;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, div_upflow, div_downflow;
  logic        m_valid, m_ready, m_upflow, m_downflow;
  logic [15:0] div_out, m_data, ovf_cnt;
  logic [15:0] op_a, op_b;

  // Second instance with LAT=1 reaches counter saturation quickly.
  logic        s_rst, s_in_valid, s_in_ready, s_m_valid, s_m_ready, s_m_upflow, s_m_downflow;
  logic [15:0] s_m_data, s_ovf_cnt;

  int checks = 0;
  int passed = 0;

  logic [15:0] fa [4];
  logic [15:0] fb [4];
  logic [15:0] fe [4];

  fixed_point_div_collector #(.WOI(8), .WOF(8), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .div_out(div_out), .div_upflow(div_upflow), .div_downflow(div_downflow),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_upflow(m_upflow), .m_downflow(m_downflow), .ovf_cnt(ovf_cnt)
  );

  fixed_point_div_collector #(.WOI(8), .WOF(8), .LAT(1), .DEPTH(4)) sat (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .div_out(16'h7FFF), .div_upflow(1'b1), .div_downflow(1'b0),
    .m_valid(s_m_valid), .m_ready(s_m_ready), .m_data(s_m_data),
    .m_upflow(s_m_upflow), .m_downflow(s_m_downflow), .ovf_cnt(s_ovf_cnt)
  );

  function automatic logic [17:0] model_div(input logic [15:0] a, input logic [15:0] b);
    longint num, den, q;
    num = longint'($signed(a)) * 256;
    den = longint'($signed(b));
    if (den == 0) return 18'h0;
    q = num / den;
    if (q > 32767)  return {2'b10, 16'h7FFF};
    if (q < -32768) return {2'b01, 16'h8000};
    return {2'b00, q[15:0]};
  endfunction

  logic [17:0] mres;
  logic [15:0] pq [LAT];
  logic        pu [LAT];
  logic        pd [LAT];

  assign mres = model_div(op_a, op_b);

  always @(posedge clk) begin
    pq[0] <= mres[15:0];
    pu[0] <= mres[17];
    pd[0] <= mres[16];
    for (int i = 1; i < LAT; i++) begin
      pq[i] <= pq[i-1];
      pu[i] <= pu[i-1];
      pd[i] <= pd[i-1];
    end
  end

  assign div_out      = pq[LAT-1];
  assign div_upflow   = pu[LAT-1];
  assign div_downflow = pd[LAT-1];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!m_valid && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (m_valid !== 1'b1) $display("FAIL %s: m_valid got %b expected 1 within 20 cycles", name, m_valid);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (ovf_cnt !== 16'h0) $display("FAIL reset_ovf_cnt: got %h expected 0000", ovf_cnt); else passed++;
  endtask

  task automatic test_single();
    op_a = 16'h0100; op_b = 16'h0200; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) $display("FAIL single_ready_pre: got %b expected 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (m_valid !== 1'b0) $display("FAIL single_no_early: m_valid got %b expected 0", m_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL single_ready_held: got %b expected 1", in_ready); else passed++;
    tick(); tick();
    checks++; if (m_valid !== 1'b1) $display("FAIL single_m_valid: got %b expected 1", m_valid); else passed++;
    checks++; if (m_data !== 16'h0080) $display("FAIL single_m_data: got %h expected 0080", m_data); else passed++;
    checks++; if (m_upflow !== 1'b0) $display("FAIL single_m_upflow: got %b expected 0", m_upflow); else passed++;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) $display("FAIL single_popped: m_valid got %b expected 0", m_valid); else passed++;
  endtask

  task automatic test_fill();
    int n = 0;
    logic ir;
    fa[0] = 16'h0100; fb[0] = 16'h0200; fe[0] = 16'h0080;
    fa[1] = 16'h0300; fb[1] = 16'h0100; fe[1] = 16'h0300;
    fa[2] = 16'h0100; fb[2] = 16'h0400; fe[2] = 16'h0040;
    fa[3] = 16'hFF00; fb[3] = 16'h0200; fe[3] = 16'hFF80;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      op_a = fa[n % 4];
      op_b = fb[n % 4];
      ir = in_ready;
      checks++;
      if (ir !== (c < 4)) $display("FAIL fill_in_ready c=%0d: got %b expected %b", c, ir, (c < 4));
      else passed++;
      tick();
      if (ir) n++;
    end
    in_valid = 1'b0;
    checks++; if (n != 4) $display("FAIL fill_launches: got %0d expected 4", n); else passed++;
    checks++; if (dut.u_fifo.occupancy !== 3'd4) $display("FAIL fill_occupancy: got %0d expected 4", dut.u_fifo.occupancy); else passed++;
  endtask

  task automatic test_drain();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid !== 1'b1) $display("FAIL drain_valid i=%0d: got %b expected 1", i, m_valid); else passed++;
      checks++; if (m_data !== fe[i]) $display("FAIL drain_data i=%0d: got %h expected %h", i, m_data, fe[i]); else passed++;
      tick();
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) $display("FAIL drain_credit: in_ready got %b expected 1", in_ready); else passed++;
      end
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) $display("FAIL drain_empty: m_valid got %b expected 0", m_valid); else passed++;
  endtask

  task automatic test_overflow();
    op_a = 16'h7F00; op_b = 16'h0001; in_valid = 1'b1;
    tick();
    op_a = 16'h8000; op_b = 16'h0001;
    tick();
    in_valid = 1'b0;
    wait_valid("ovf_wait_up");
    checks++; if (m_upflow !== 1'b1) $display("FAIL ovf_upflow: got %b expected 1", m_upflow); else passed++;
    checks++; if (m_data !== 16'h7FFF) $display("FAIL ovf_up_data: got %h expected 7fff", m_data); else passed++;
    checks++; if (ovf_cnt !== 16'h0) $display("FAIL ovf_cnt_before: got %h expected 0000", ovf_cnt); else passed++;
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    checks++; if (ovf_cnt !== 16'h1) $display("FAIL ovf_cnt_up: got %h expected 0001", ovf_cnt); else passed++;
    wait_valid("ovf_wait_down");
    checks++; if ({m_upflow, m_downflow} !== 2'b01) $display("FAIL ovf_downflow: got %b expected 01", {m_upflow, m_downflow}); else passed++;
    checks++; if (m_data !== 16'h8000) $display("FAIL ovf_down_data: got %h expected 8000", m_data); else passed++;
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    checks++; if (ovf_cnt !== 16'h2) $display("FAIL ovf_cnt_down: got %h expected 0002", ovf_cnt); else passed++;
  endtask

  task automatic test_simultaneous();
    op_a = 16'h0200; op_b = 16'h0100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("simul_wait");
    op_a = 16'h0100; op_b = 16'h0100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    m_ready = 1'b1;
    checks++; if (m_data !== 16'h0200) $display("FAIL simul_head: got %h expected 0200", m_data); else passed++;
    tick();
    m_ready = 1'b0;
    checks++; if (dut.u_fifo.occupancy !== 3'd1) $display("FAIL simul_occupancy: got %0d expected 1", dut.u_fifo.occupancy); else passed++;
    checks++; if (m_valid !== 1'b1) $display("FAIL simul_valid: got %b expected 1", m_valid); else passed++;
    checks++; if (m_data !== 16'h0100) $display("FAIL simul_next: got %h expected 0100", m_data); else passed++;
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) $display("FAIL simul_empty: m_valid got %b expected 0", m_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    op_a = 16'h0400; op_b = 16'h0100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("rstmid_wait");
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (m_valid !== 1'b0) $display("FAIL rstmid_m_valid: got %b expected 0", m_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (ovf_cnt !== 16'h0) $display("FAIL rstmid_ovf_cnt: got %h expected 0000", ovf_cnt); else passed++;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (m_valid) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rstmid_ghost: m_valid seen %0d cycles expected 0", bad); else passed++;
    checks++; if (dut.u_fifo.occupancy !== 3'd0) $display("FAIL rstmid_occupancy: got %0d expected 0", dut.u_fifo.occupancy); else passed++;
  endtask

  task automatic test_saturate();
    int pops = 0;
    int cyc = 0;
    logic p;
    s_rst = 1'b1; s_in_valid = 1'b1; s_m_ready = 1'b1;
    while (pops < 70000 && cyc < 80000) begin
      p = s_m_valid && s_m_ready;
      tick();
      cyc++;
      if (p) begin
        pops++;
        if (pops == 65534) begin
          checks++; if (s_ovf_cnt !== 16'hFFFE) $display("FAIL sat_at_65534: got %h expected fffe", s_ovf_cnt); else passed++;
        end
        if (pops == 65535) begin
          checks++; if (s_ovf_cnt !== 16'hFFFF) $display("FAIL sat_at_65535: got %h expected ffff", s_ovf_cnt); else passed++;
        end
      end
    end
    s_in_valid = 1'b0;
    checks++; if (pops != 70000) $display("FAIL sat_pop_count: got %0d expected 70000", pops); else passed++;
    checks++; if (s_ovf_cnt !== 16'hFFFF) $display("FAIL sat_final: got %h expected ffff", s_ovf_cnt); else passed++;
    checks++; if (s_m_upflow !== 1'b1 && s_m_valid) $display("FAIL sat_head_upflow: got %b expected 1", s_m_upflow); else passed++;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; m_ready = 1'b0;
    op_a = 16'h0; op_b = 16'h0001;
    s_rst = 1'b0; s_in_valid = 1'b0; s_m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_div_collector.md
FIXED_POINT_DIV_COLLECTOR -- requirements
Module: fixed_point_div_collector

Interface
REQ-001 SHALL have parameter WOI, default 8, integer bits of the divider quotient.
REQ-002 SHALL have parameter WOF, default 8, fractional bits of the divider quotient.
REQ-003 SHALL have parameter LAT, default 4, divider latency in cycles from operand launch to quotient valid; LAT >= 1.
REQ-004 SHALL have parameter DEPTH, default 4, result buffer entries; power of two, >= 2.
REQ-005 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  upstream presents an operand pair to the divider this cycle.
REQ-008 SHALL have port in_ready  output  1  a launch is permitted this cycle.
REQ-009 SHALL have port div_out  input  WOI+WOF  divider quotient, two's complement.
REQ-010 SHALL have port div_upflow  input  1  divider positive-overflow flag.
REQ-011 SHALL have port div_downflow  input  1  divider negative-overflow flag.
REQ-012 SHALL have port m_valid  output  1  buffered result available.
REQ-013 SHALL have port m_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port m_data  output  WOI+WOF  head-of-buffer quotient.
REQ-015 SHALL have port m_upflow  output  1  head-of-buffer upflow flag.
REQ-016 SHALL have port m_downflow  output  1  head-of-buffer downflow flag.
REQ-017 SHALL have port ovf_cnt  output  16  count of accepted results with upflow or downflow set.

Function
REQ-018 Launch = in_valid && in_ready; SHALL enter a LAT-stage tag shift register, advancing every cycle.
REQ-019 A launch sampled at edge t SHALL cause div_out/flags sampled at edge t+LAT to be written into the buffer; no other cycle writes.
REQ-020 in_ready SHALL be combinational: 1 iff occupancy + in-flight tags < DEPTH; buffer therefore never overflows and no result is dropped.
REQ-021 Pop = m_valid && m_ready; m_valid = (occupancy != 0); m_data/m_upflow/m_downflow SHALL reflect the oldest entry, stable while m_valid && !m_ready.
REQ-022 Results SHALL leave in launch order.
REQ-023 Write into empty buffer SHALL give m_valid the following cycle; no same-cycle bypass.
REQ-024 Simultaneous write and pop SHALL leave occupancy unchanged, both taking effect.
REQ-025 A pop SHALL raise in_ready in the cycle after the pop edge when the credit limit was the only cause of in_ready=0.
REQ-026 ovf_cnt SHALL increment by 1 per pop with m_upflow || m_downflow; saturates at 0xFFFF.
REQ-027 Pointers SHALL wrap modulo DEPTH; occupancy range 0..DEPTH inclusive.

Reset
REQ-028 When rst=0 at an edge: tags, pointers, occupancy, ovf_cnt SHALL clear; m_valid=0, in_ready=1 the following cycle.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered results; divider outputs arriving after reset SHALL NOT be written.
REQ-030 Buffer storage need not reset; only its control state does.

Structure
REQ-031 A shared package SHALL hold the result-entry struct {data, upflow, downflow} and the ovf_cnt width constant.
REQ-032 The buffer SHALL be one sub-module, fixed_point_result_fifo (synchronous, DEPTH entries, occupancy output).
REQ-033 Tag pipeline, credit logic and counter SHALL live in the top module.

Verification (WOI=8, WOF=8, LAT=4, DEPTH=4; bench models divider as LAT-cycle delay)
REQ-034 Single launch, edge 0, 0x0100/0x0200, model returns 0x0080 at edge 4 -> m_valid=1 with m_data=0x0080 after edge 5, in_ready held 1.
REQ-035 m_ready=0, in_valid=1 continuous -> exactly 4 launches accepted, in_ready=0 from cycle 4 onward, occupancy ends at 4.
REQ-036 Then m_ready=1 -> 4 pops in launch order on consecutive cycles; in_ready=1 the cycle after the first pop.
REQ-037 Result with div_upflow=1 popped -> m_upflow=1, ovf_cnt +1; ovf_cnt preloaded near 0xFFFF by 70000 overflow pops -> stays 0xFFFF.
REQ-038 Occupancy 1, write and pop at same edge -> occupancy 1, m_valid stays 1, next entry presented.
REQ-039 rst=0 for one edge with 3 launches in flight -> m_valid=0, in_ready=1, no result appears within 2*LAT cycles.
